phase_seq: RTL and testbench
============================

# phase_seq

Parametrised multi-cycle phase sequencer for the `micro` core. It drives the one-hot phase vector that the PC, instruction register, register file and memory blocks use to qualify their updates. It generalises the fixed fetch/read/execute/memory/write cycle in three ways:
- the phase count is configurable;
- individual phases can be skipped per instruction;
- the sequence can be stalled or halted, and instruction retirements are counted.

## Interface
- NPHASE, 5, number of phases; bit NPHASE-1 is fetch, bit 0 is the final (write) phase; minimum 2
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold the current phase this cycle
- skip_mask  in  NPHASE  1 = skip that phase when advancing; bit NPHASE-1 (fetch) ignored
- halt  in  1  enter HALTED instead of fetch at end of the current instruction
- resume  in  1  leave HALTED
- phase  out  NPHASE  one-hot current phase, all zeros when halted
- halted  out  1  sequencer is in HALTED
- inst_done  out  1  one-cycle pulse, an instruction just completed
- retired  out  CNT_W  count of completed instructions

## Operation
- States: RUN (phase one-hot) and HALTED (phase = 0, halted = 1).
- Priority, highest first: rst > stall > advance.
- rst high at an edge, from any state and mid-instruction:
  - phase = 1 << (NPHASE-1) (fetch);
  - halted = 0, inst_done = 0, retired = 0.
- RUN with stall = 1: phase holds; inst_done = 0; skip_mask, halt and resume are ignored.
- RUN with stall = 0, current bit k: the next phase is the highest bit j < k with skip_mask[j] = 0.
- Wrap: if no such j exists (including k = 0), the instruction ends.
  - halt = 0: next phase = fetch.
  - halt = 1: go to HALTED.
  - Either way, inst_done is pulsed and retired increments.
- skip_mask and halt are sampled on the edge that leaves the current phase. The core must hold skip_mask stable from decode onward.
- Fetch is never skipped. With skip_mask = all ones on bits NPHASE-2..0, the sequence is fetch→fetch, and each fetch retires one instruction.
- retired wraps from 2^CNT_W−1 to 0. There is no saturation and no flag.
- HALTED:
  - resume = 1: next phase = fetch, halted = 0.
  - resume = 0: remain in HALTED.
  - stall is ignored.
  - No retirements occur in HALTED.
- halt asserted while stalled has no effect until the stall is released at the wrap edge.
- halt and resume both high at a wrap edge: HALTED is entered (resume is only examined in HALTED).

## Timing
- All outputs are registered and change only on rising clk.
- Reset values: phase = fetch one-hot, halted = 0, inst_done = 0, retired = 0.
- Advance latency is 1 cycle: a phase not stalled lasts exactly one cycle.
- An instruction with no skips and no stalls takes NPHASE cycles. Each skipped phase removes one cycle; each stall cycle adds one.
- inst_done is high for exactly the one cycle following the wrap edge. That is either the first cycle of the next fetch or the first HALTED cycle.
- retired shows the incremented value in the same cycle inst_done is high.
- Resume latency: resume sampled high on edge N → phase = fetch after edge N.
- phase is always exactly one-hot in RUN and zero in HALTED. Any other value is a design error that verification must flag.

## Test plan
- Reset, NPHASE = 5, skip_mask = 0, no stall, run 10 cycles:
  - phase sequence 10000, 01000, 00100, 00010, 00001, repeating;
  - inst_done high in cycles 6 and 11 after reset release;
  - retired = 2.
- skip_mask = 00110 (skip memory and execute): sequence 10000 → 01000 → 00001 → 10000; 3 cycles per instruction.
- stall held for 3 cycles while phase = 00100:
  - phase stays 00100 for 4 cycles;
  - the instruction takes 8 cycles;
  - skip_mask changes during the stall are ignored.
- halt = 1 during write phase:
  - next edge gives phase = 00000, halted = 1, inst_done pulse, retired+1;
  - held in HALTED for 5 cycles with stall toggling;
  - resume pulse → phase = 10000, halted = 0 on the next cycle.
- CNT_W = 3, all phases skipped: phase stays 10000 and retired counts 1..7 → 0; inst_done is high every cycle.
- rst asserted while phase = 00010 with retired = 5 → next cycle phase = 10000, retired = 0, inst_done = 0, halted = 0. Repeat the reset from HALTED with the same result.

Source files
------------

// File: rtl/phase_seq.sv
// Multi-cycle phase sequencer: walks a one-hot phase vector from fetch down to
// write, skipping masked phases, with stall, halt/resume and a retirement count.
module phase_seq #(
   parameter int NPHASE = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [NPHASE-1:0] skip_mask,
   input  logic              halt,
   input  logic              resume,
   output logic [NPHASE-1:0] phase,
   output logic              halted,
   output logic              inst_done,
   output logic [CNT_W-1:0]  retired
);

   localparam logic ST_RUN    = 1'b0;
   localparam logic ST_HALTED = 1'b1;

   localparam logic [NPHASE-1:0] FETCH   = {1'b1, {(NPHASE-1){1'b0}}};
   localparam logic [NPHASE-1:0] ONE_HOT0 = {{(NPHASE-1){1'b0}}, 1'b1};

   logic              state;
   logic [NPHASE-1:0] below;
   logic [NPHASE-1:0] cand;
   logic [NPHASE-1:0] nxt_phase;
   logic              wrap;

   // For a one-hot phase, phase-1 sets every bit strictly below the current
   // one; fetch is never a candidate, so its skip bit is ignored for free.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      below     = phase - ONE_HOT0;
      cand      = below & ~skip_mask;
      nxt_phase = '0;
      for (int j = 0; j < NPHASE; j++) begin
         if (cand[j]) begin
            nxt_phase    = '0;
            nxt_phase[j] = 1'b1;
         end
      end
      wrap = (cand == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         phase     <= FETCH;
         inst_done <= 1'b0;
         retired   <= '0;
      end else begin
         inst_done <= 1'b0;
         if (state == ST_RUN) begin
            if (!stall) begin
               if (wrap) begin
                  inst_done <= 1'b1;
                  retired   <= retired + CNT_W'(1);
                  if (halt) begin
                     state <= ST_HALTED;
                     phase <= '0;
                  end else begin
                     phase <= FETCH;
                  end
               end else begin
                  phase <= nxt_phase;
               end
            end
         end else if (resume) begin
            state <= ST_RUN;
            phase <= FETCH;
         end
      end
   end

   assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_phase_seq.sv
// Directed self-checking bench for phase_seq: sequencing, skips, stall,
// halt/resume, reset and counter wrap on a narrow-counter instance.
module tb_phase_seq;

   localparam int NP = 5;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, stall, halt, resume;
   logic [NP-1:0] skip_mask;
   logic [NP-1:0] phase;
   logic          halted, inst_done;
   logic [31:0]   retired;

   logic          rst_w, stall_w, halt_w, resume_w;
   logic [NP-1:0] skip_w;
   logic [NP-1:0] phase_w;
   logic          halted_w, inst_done_w;
   logic [2:0]    retired_w;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ret  = 0;

   phase_seq #(.NPHASE(NP), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .skip_mask(skip_mask),
      .halt(halt), .resume(resume), .phase(phase), .halted(halted),
      .inst_done(inst_done), .retired(retired)
   );

   phase_seq #(.NPHASE(NP), .CNT_W(3)) dut_w (
      .clk(clk), .rst(rst_w), .stall(stall_w), .skip_mask(skip_w),
      .halt(halt_w), .resume(resume_w), .phase(phase_w), .halted(halted_w),
      .inst_done(inst_done_w), .retired(retired_w)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge and check the full output set of the main instance.
   task automatic expect_cycle(input string tag, input logic [NP-1:0] ph, input logic done);
      step();
      if (done) exp_ret++;
      check({tag, "_phase"},  phase, ph);
      check({tag, "_done"},   inst_done, done);
      check({tag, "_halted"}, halted, (ph == '0));
      check({tag, "_ret"},    retired, exp_ret);
      check({tag, "_legal"},
            (($countones(phase) == 1) && !halted) || ((phase == '0) && halted), 1'b1);
   endtask

   task automatic expect_reset(input string tag);
      rst = 1'b1;
      step();
      exp_ret = 0;
      check({tag, "_phase"},  phase, 5'b10000);
      check({tag, "_halted"}, halted, 1'b0);
      check({tag, "_done"},   inst_done, 1'b0);
      check({tag, "_ret"},    retired, 0);
      rst = 1'b0;
   endtask

   logic [NP-1:0] seq_plain [10] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000,
                                     5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

   initial begin
      rst = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0; skip_mask = '0;
      rst_w = 1'b1; stall_w = 1'b0; halt_w = 1'b0; resume_w = 1'b0; skip_w = '1;

      // Reset, then two plain instructions of five cycles each.
      expect_reset("rst0");
      for (int i = 0; i < 10; i++)
         expect_cycle("plain", seq_plain[i], (i == 4) || (i == 9));
      check("plain_ret2", retired, 2);

      // Skip execute and memory: fetch, read, write.
      skip_mask = 5'b00110;
      for (int i = 0; i < 2; i++) begin
         expect_cycle("skip0110_a", 5'b01000, 1'b0);
         expect_cycle("skip0110_b", 5'b00001, 1'b0);
         expect_cycle("skip0110_c", 5'b10000, 1'b1);
      end

      // Skip the final phase: instruction ends from phase 00010.
      skip_mask = 5'b00101;
      expect_cycle("skip0101_a", 5'b01000, 1'b0);
      expect_cycle("skip0101_b", 5'b00010, 1'b0);
      expect_cycle("skip0101_c", 5'b10000, 1'b1);

      // Stall three cycles in 00100 while skip_mask wiggles.
      skip_mask = '0;
      expect_cycle("stall_a", 5'b01000, 1'b0);
      expect_cycle("stall_b", 5'b00100, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         skip_mask = (i[0]) ? 5'b00011 : 5'b11111;
         expect_cycle("stall_hold", 5'b00100, 1'b0);
      end
      stall = 1'b0; skip_mask = '0;
      expect_cycle("stall_c", 5'b00010, 1'b0);
      expect_cycle("stall_d", 5'b00001, 1'b0);
      expect_cycle("stall_e", 5'b10000, 1'b1);

      // Halt requested while stalled at write, taking effect on release.
      for (int i = 0; i < 4; i++)
         expect_cycle("halt_walk", seq_plain[i], 1'b0);
      stall = 1'b1; halt = 1'b1;
      expect_cycle("halt_stalled", 5'b00001, 1'b0);
      expect_cycle("halt_stalled", 5'b00001, 1'b0);
      stall = 1'b0;
      expect_cycle("halt_enter", 5'b00000, 1'b1);
      halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stall = i[0];
         expect_cycle("halt_hold", 5'b00000, 1'b0);
      end
      stall = 1'b0; resume = 1'b1;
      expect_cycle("resume", 5'b10000, 1'b0);
      resume = 1'b0;

      // Halt and resume together at the wrap edge: halt wins.
      for (int i = 0; i < 4; i++)
         expect_cycle("hr_walk", seq_plain[i], 1'b0);
      halt = 1'b1; resume = 1'b1;
      expect_cycle("hr_enter", 5'b00000, 1'b1);
      halt = 1'b0;
      expect_cycle("hr_resume", 5'b10000, 1'b0);
      resume = 1'b0;

      // Reset mid-instruction, then reset from HALTED.
      for (int i = 0; i < 3; i++)
         expect_cycle("rst_walk", seq_plain[i], 1'b0);
      check("rst_pre_ret", retired, exp_ret);
      expect_reset("rst_mid");
      for (int i = 0; i < 4; i++)
         expect_cycle("rst_walk2", seq_plain[i], 1'b0);
      halt = 1'b1;
      expect_cycle("rst_halt", 5'b00000, 1'b1);
      halt = 1'b0;
      expect_reset("rst_halted");

      // Narrow counter, everything skipped: fetch every cycle, wrap 7 -> 0.
      step();
      check("w_rst_ret", retired_w, 3'd0);
      check("w_rst_phase", phase_w, 5'b10000);
      rst_w = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("w_phase", phase_w, 5'b10000);
         check("w_done",  inst_done_w, 1'b1);
         check("w_halted", halted_w, 1'b0);
         check("w_ret",   retired_w, i % 8);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
